// File: rtl/cdr_scan_driver_if.sv
// Pattern-in / response-out handshake bundle for the CDR scan driver.
// The driver uses the slave view; the pattern source / response sink uses master.
interface cdr_scan_driver_if #(
    parameter int CHAIN_LEN = 8
);
    logic [CHAIN_LEN-1:0] pat_data;
    logic [CHAIN_LEN-1:0] pat_exp;
    logic [CHAIN_LEN-1:0] pat_mask;
    logic                 pat_capture;
    logic                 pat_valid;
    logic                 pat_ready;

    logic [CHAIN_LEN-1:0] rsp_data;
    logic                 rsp_fail;
    logic                 rsp_valid;
    logic                 rsp_ready;

    modport master (
        output pat_data, pat_exp, pat_mask, pat_capture, pat_valid, rsp_ready,
        input  pat_ready, rsp_data, rsp_fail, rsp_valid
    );

    modport slave (
        input  pat_data, pat_exp, pat_mask, pat_capture, pat_valid, rsp_ready,
        output pat_ready, rsp_data, rsp_fail, rsp_valid
    );
endinterface

// File: rtl/cdr_scan_driver.sv
// Scan-side master for the CDR chain: shifts a stimulus word in while unloading
// the previous contents, optionally holds se low for a capture window, then returns the response.
module cdr_scan_driver #(
    parameter int CHAIN_LEN      = 8,
    parameter int CAPTURE_CYCLES = 1,
    parameter int CNT_W          = $clog2(CHAIN_LEN + CAPTURE_CYCLES) + 1
) (
    input  logic                    CLK,
    input  logic                    CoreIN_RESET,
    cdr_scan_driver_if.slave        bus,
    output logic                    ScanChainIN,
    output logic                    se,
    input  logic                    ScanChainOut,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CHAIN_LEN + CAPTURE_CYCLES - 1);

    state_t               state_q;
    logic [CHAIN_LEN-1:0] tx_q;
    logic [CHAIN_LEN-1:0] rx_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic                 cap_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sin_q;
    logic                 se_q;
    logic                 busy_q;
    logic [CHAIN_LEN-1:0] rsp_data_q;
    logic                 rsp_fail_q;
    logic                 rsp_valid_q;

    logic [CHAIN_LEN-1:0] rx_d;
    logic                 rsp_fail_d;
    logic [CNT_W-1:0]     cnt_d;

    // The chain output sampled here is the bit present before the CDR shifts on this edge.
    always_comb begin
        rx_d       = {ScanChainOut, rx_q[CHAIN_LEN-1:1]};
        rsp_fail_d = |((rx_d ^ exp_q) & mask_q);
        cnt_d      = (cnt_q == CAP_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            exp_q       <= '0;
            mask_q      <= '0;
            cap_q       <= 1'b0;
            cnt_q       <= '0;
            sin_q       <= 1'b0;
            se_q        <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fail_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pat_valid) begin
                        tx_q    <= bus.pat_data >> 1;
                        exp_q   <= bus.pat_exp;
                        mask_q  <= bus.pat_mask;
                        cap_q   <= bus.pat_capture;
                        cnt_q   <= '0;
                        se_q    <= 1'b1;
                        sin_q   <= bus.pat_data[0];
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    rx_q  <= rx_d;
                    tx_q  <= tx_q >> 1;
                    sin_q <= tx_q[0];
                    cnt_q <= cnt_d;
                    if (cnt_q == SHIFT_LAST) begin
                        se_q       <= 1'b0;
                        sin_q      <= 1'b0;
                        rsp_data_q <= rx_d;
                        rsp_fail_q <= rsp_fail_d;
                        if (cap_q) begin
                            state_q <= CAPTURE;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end

                // se stays low so the CDR can load functional data; the chain output is ignored.
                CAPTURE: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CAP_LAST) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pat_ready = (state_q == IDLE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fail  = rsp_fail_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign ScanChainIN   = sin_q;
    assign se            = se_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cdr_scan_driver.sv
// Self-checking bench for cdr_scan_driver: an 8-cell CDR model on the chain side and a
// scoreboard of expected responses filled on each accept and drained on each response handshake.
module tb_cdr_scan_driver;

    localparam int N   = 8;
    localparam int CAP = 3;

    logic clk;
    logic rst;
    logic sin;
    logic se;
    logic sout;
    logic busy;

    cdr_scan_driver_if #(.CHAIN_LEN(N)) bus ();

    cdr_scan_driver #(
        .CHAIN_LEN      (N),
        .CAPTURE_CYCLES (CAP)
    ) dut (
        .CLK          (clk),
        .CoreIN_RESET (rst),
        .bus          (bus),
        .ScanChainIN  (sin),
        .se           (se),
        .ScanChainOut (sout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CDR model: shifts toward cell 0 only while se is high.
    logic [N-1:0] cdr;
    always @(posedge clk or posedge rst) begin
        if (rst) cdr <= '0;
        else if (se) cdr <= {sin, cdr[N-1:1]};
    end
    assign sout = cdr[0];

    typedef struct packed {
        logic [N-1:0] data;
        logic         fail;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [N-1:0] img      = '0;
    logic [N-1:0] cur_pat  = '0;
    int           acc_edge = 0;
    logic         acc_cap  = 1'b0;
    int           last_acc = -1;
    logic         streaming = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor on the falling edge: everything is stable between active edges.
    initial begin : monitor
        logic         prev_rv;
        logic         prev_se;
        int           se_cnt;
        int           cap_cnt;
        logic [N-1:0] sin_bits;
        exp_t         e;
        prev_rv  = 1'b0;
        prev_se  = 1'b0;
        se_cnt   = 0;
        cap_cnt  = 0;
        sin_bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rv = 1'b0;
                prev_se = 1'b0;
                se_cnt  = 0;
                cap_cnt = 0;
            end else begin
                if (se) begin
                    sin_bits = {sin, sin_bits[N-1:1]};
                    se_cnt++;
                end
                if (prev_se && !se) begin
                    check_val("se_len", se_cnt, N);
                    check_val("sin_seq", sin_bits, cur_pat);
                    se_cnt = 0;
                end
                if (busy && !se && !bus.rsp_valid) begin
                    check_val("cdr_hold", cdr, cur_pat);
                    cap_cnt++;
                end
                if (bus.rsp_valid && !prev_rv) begin
                    check_val("latency", cyc - acc_edge, acc_cap ? N + CAP : N);
                    check_val("cap_len", cap_cnt, acc_cap ? CAP : 0);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        check_val("unexpected_rsp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_val("rsp_data", bus.rsp_data, e.data);
                        check_val("rsp_fail", bus.rsp_fail, e.fail);
                    end
                end
                if (bus.pat_valid && bus.pat_ready) begin
                    e.data = img;
                    e.fail = |((img ^ bus.pat_exp) & bus.pat_mask);
                    sb.push_back(e);
                    img      = bus.pat_data;
                    cur_pat  = bus.pat_data;
                    acc_edge = cyc + 1;
                    acc_cap  = bus.pat_capture;
                    cap_cnt  = 0;
                    if (streaming && last_acc >= 0)
                        check_val("period", acc_edge - last_acc, N + 2);
                    last_acc = acc_edge;
                end
                prev_rv = bus.rsp_valid;
                prev_se = se;
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic [N-1:0] e,
                        input logic [N-1:0] m, input logic cap);
        int t;
        bus.pat_data    = d;
        bus.pat_exp     = e;
        bus.pat_mask    = m;
        bus.pat_capture = cap;
        bus.pat_valid   = 1'b1;
        t = 0;
        while (!bus.pat_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.pat_ready) check_val("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.pat_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("drain_timeout", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        check_val("watchdog", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : main
        logic [N-1:0] stream_pats [4];
        int           seen;
        int           t;
        stream_pats = '{8'h12, 8'h34, 8'h56, 8'h78};

        rst             = 1'b1;
        bus.pat_data    = '0;
        bus.pat_exp     = '0;
        bus.pat_mask    = '0;
        bus.pat_capture = 1'b0;
        bus.pat_valid   = 1'b0;
        bus.rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_pat_ready", bus.pat_ready, 1);
        check_val("rst_se", se, 0);
        check_val("rst_sin", sin, 0);
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_rsp_data", bus.rsp_data, 0);
        check_val("rst_busy", busy, 0);

        // Basic load, then compare tests with exact, mismatching and masked expectations.
        send(8'hA5, 8'h00, 8'hFF, 1'b0); drain();
        send(8'h3C, 8'hA5, 8'hFF, 1'b0); drain();
        send(8'hA5, 8'h00, 8'h00, 1'b0); drain();
        send(8'h3C, 8'hA4, 8'hFF, 1'b0); drain();
        send(8'hA5, 8'h00, 8'h00, 1'b0); drain();
        send(8'h3C, 8'hA4, 8'hFE, 1'b0); drain();

        // Capture phase.
        send(8'h5A, 8'h3C, 8'hFF, 1'b1); drain();
        send(8'hC3, 8'h00, 8'h0F, 1'b1); drain();

        // Response backpressure with a competing pattern held valid.
        bus.rsp_ready = 1'b0;
        send(8'h77, 8'hC3, 8'hFF, 1'b0);
        t = 0;
        while (!bus.rsp_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_val("bp_rsp_seen", bus.rsp_valid, 1);
        bus.pat_data    = 8'h11;
        bus.pat_exp     = 8'h77;
        bus.pat_mask    = 8'hFF;
        bus.pat_capture = 1'b0;
        bus.pat_valid   = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_val("bp_rsp_valid", bus.rsp_valid, 1);
            check_val("bp_rsp_data", bus.rsp_data, sb[0].data);
            check_val("bp_rsp_fail", bus.rsp_fail, sb[0].fail);
            check_val("bp_pat_ready", bus.pat_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_hs_pat_ready", bus.pat_ready, 1);
        check_val("bp_hs_rsp_valid", bus.rsp_valid, 0);
        check_val("bp_hs_busy", busy, 0);
        @(posedge clk); #1;
        bus.pat_valid = 1'b0;
        check_val("bp_acc_busy", busy, 1);
        check_val("bp_acc_se", se, 1);
        check_val("bp_acc_sin", sin, 1);
        drain();

        // Continuous pat_valid: one accept every N+2 cycles, responses in order.
        streaming = 1'b1;
        last_acc  = -1;
        bus.pat_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pat_data    = stream_pats[i];
            bus.pat_exp     = 8'h5A ^ 8'(i);
            bus.pat_mask    = 8'hF0;
            bus.pat_capture = 1'b0;
            t = 0;
            while (!bus.pat_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (!bus.pat_ready) check_val("stream_timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.pat_valid = 1'b0;
        drain();
        streaming = 1'b0;

        // Reset in the middle of a shift aborts without a response.
        send(8'hE7, 8'h00, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("abort_se", se, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_rsp_valid", bus.rsp_valid, 0);
        check_val("abort_pat_ready", bus.pat_ready, 1);
        sb.delete();
        img = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        check_val("abort_no_rsp", seen, 0);

        // Recovery after abort: chain model was reset, so the unload is zero.
        send(8'h81, 8'h01, 8'h01, 1'b0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
